// File: rtl/alu_serial_nbit.sv
// Bit-serial n-bit ALU: one operation per request, processed LSB-first at one bit per clock.
// Define ALU_FLAGS_EN to add the registered zero and signed-overflow outputs.
module alu_serial_nbit #(
    parameter int X = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [X-1:0] a,
    input  logic [X-1:0] b,
    input  logic         c_in,
    input  logic [2:0]   ALop,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [X:0]   result
`ifdef ALU_FLAGS_EN
    ,
    output logic         zero,
    output logic         ovf
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_AND  = 3'b000, OP_OR  = 3'b001, OP_XOR  = 3'b010, OP_NOR = 3'b011,
        OP_ADD  = 3'b100, OP_SUB = 3'b101, OP_PASS = 3'b110, OP_NOT = 3'b111
    } op_t;

    localparam int              CW       = $clog2(X + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(X - 1);

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [X-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic          carry_q, carry_d, top_q, top_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef ALU_FLAGS_EN
    logic          zero_q, zero_d, ovf_q, ovf_d;
`endif

    logic a_bit, b_eff, sum_bit, cout_bit, r_bit, is_arith;

    // SUB is a + ~b + c_in, so only the B bit entering the adder is inverted.
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign a_bit    = a_q[0];
    assign b_eff    = (op_q == OP_SUB) ? ~b_q[0] : b_q[0];
    assign sum_bit  = a_bit ^ b_eff ^ carry_q;
    assign cout_bit = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

    // NOTE: every _d is given its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        top_d   = top_q;
        cnt_d   = cnt_q;
`ifdef ALU_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        unique case (op_q)
            OP_AND:  r_bit = a_bit & b_q[0];
            OP_OR:   r_bit = a_bit | b_q[0];
            OP_XOR:  r_bit = a_bit ^ b_q[0];
            OP_NOR:  r_bit = ~(a_bit | b_q[0]);
            OP_PASS: r_bit = a_bit;
            OP_NOT:  r_bit = ~a_bit;
            default: r_bit = sum_bit;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_SHIFT;
                    op_d    = op_t'(ALop);
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                res_d   = {r_bit, res_q[X-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = is_arith ? cout_bit : carry_q;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    // The top result bit reports borrow for SUB, i.e. the inverted adder carry.
                    top_d   = (op_q == OP_ADD) ? cout_bit :
                              (op_q == OP_SUB) ? ~cout_bit : 1'b0;
`ifdef ALU_FLAGS_EN
                    zero_d  = ({r_bit, res_q[X-1:1]} == '0);
                    ovf_d   = is_arith & (carry_q ^ cout_bit);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_AND;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            top_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef ALU_FLAGS_EN
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            top_q   <= top_d;
            cnt_q   <= cnt_d;
`ifdef ALU_FLAGS_EN
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = {top_q, res_q};
`ifdef ALU_FLAGS_EN
    assign zero      = zero_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Scoreboard bench for alu_serial_nbit (X=32): stimulus pushes model results, a monitor pops on each response.
module tb_alu_serial_nbit;

    localparam int X = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, c_in, out_valid, out_ready;
    logic [X-1:0]  a, b;
    logic [2:0]    ALop;
    logic [X:0]    result;
`ifdef ALU_FLAGS_EN
    logic          zero, ovf;
`endif

    alu_serial_nbit #(.X(X)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .ALop(ALop),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef ALU_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [X:0] res;
        logic       z;
        logic       o;
        int         hs;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_pass = 0, n_total = 0;
    int   resp_cyc = 0, last_hs = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [X-1:0] av, bv, input logic ci);
        exp_t e;
        logic [X:0]   s;
        logic [X-1:0] bn;
        e.o = 1'b0;
        e.hs = 0;
        bn = ~bv;
        case (op)
            3'd0: e.res = {1'b0, av & bv};
            3'd1: e.res = {1'b0, av | bv};
            3'd2: e.res = {1'b0, av ^ bv};
            3'd3: e.res = {1'b0, ~(av | bv)};
            3'd4: begin
                s = {1'b0, av} + {1'b0, bv} + (X+1)'(ci);
                e.res = s;
                e.o = (av[X-1] == bv[X-1]) && (s[X-1] != av[X-1]);
            end
            3'd5: begin
                s = {1'b0, av} + {1'b0, bn} + (X+1)'(ci);
                e.res = {~s[X], s[X-1:0]};
                e.o = (av[X-1] != bv[X-1]) && (s[X-1] != av[X-1]);
            end
            3'd6: e.res = {1'b0, av};
            default: e.res = {1'b0, ~av};
        endcase
        e.z = (e.res[X-1:0] == '0);
        return e;
    endfunction

    // Monitor: latency on each rising out_valid, data on each response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) check("unexpected_valid", 64'(exp_q.size()), 64'd1);
                else check("latency", 64'(cyc - exp_q[0].hs), 64'(X));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", 64'(result), 64'(e.res));
`ifdef ALU_FLAGS_EN
                    check("zero", 64'(zero), 64'(e.z));
                    check("ovf", 64'(ovf), 64'(e.o));
`endif
                    resp_cyc = cyc + 1;
                end
            end
        end
        ov_prev = out_valid;
    end

    task automatic issue(input logic [2:0] op, input logic [X-1:0] av, bv, input logic ci);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        ALop = op; a = av; b = bv; c_in = ci; in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("hs_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        e = model(op, av, bv, ci);
        e.hs = cyc + 1;
        last_hs = e.hs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; ALop = 3'($urandom); c_in = 1'($urandom);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [X-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(X-1){1'b0}}};
            3: return {1'b0, {(X-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [X:0] held;
        int         w;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; ALop = 3'd0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
`ifdef ALU_FLAGS_EN
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk) rst_n = 1'b1;

        issue(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        issue(3'd5, 32'd5, 32'd3, 1'b1);
        issue(3'd5, 32'd3, 32'd5, 1'b1);
        issue(3'd4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("b2b_gap", 64'(last_hs - resp_cyc), 64'd1);
        issue(3'd2, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
        drain();

        // Back-pressure: hold the response while a second request is offered.
        out_ready = 1'b0;
        issue(3'd1, $urandom, $urandom, 1'b0);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid", 64'(out_valid), 64'd1);
        held = result;
        a = $urandom; b = $urandom; ALop = 3'd4; in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #2;
            check("bp_hold", 64'(result), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (40) @(negedge clk);
        check("bp_no_ghost", 64'(out_valid), 64'd0);

        // Reset part-way through an operation.
        issue(3'd4, $urandom, $urandom, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        issue(3'd4, 32'd2, 32'd2, 1'b0);
        drain();

        for (int i = 0; i < 40; i++)
            issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
